// File: rtl/led_blink_ctrl.sv
// led_blink_ctrl: multi-channel LED controller (OFF/ON/BLINK/PULSE) with a shared tick prescaler
//   Optional PWM dimming is enabled by defining macro LED_DIM_EN.
//   sclk       system clock, rising edge
//   rst_n      asynchronous active-low reset
//   cfg_we     configuration write strobe
//   cfg_ch     target channel of the write
//   cfg_mode   00 OFF, 01 ON, 10 BLINK, 11 PULSE
//   cfg_half   half-period in ticks (0 behaves as 1)
//   cfg_duty   PWM duty applied to lit phases
//   tick_o     prescaler tick, one-cycle pulse
//   led        registered LED drive, active-high
//   pulse_done one-cycle flag when a PULSE completes
module led_blink_ctrl #(
    parameter int CH_NUM   = 4,
    parameter int PRESCALE = 500,
    parameter int HALF_W   = 8,
    parameter int DIM_W    = 4,
    localparam int CW      = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic              sclk,
    input  logic              rst_n,
    input  logic              cfg_we,
    input  logic [CW-1:0]     cfg_ch,
    input  logic [1:0]        cfg_mode,
    input  logic [HALF_W-1:0] cfg_half,
    input  logic [DIM_W-1:0]  cfg_duty,
    output logic              tick_o,
    output logic [CH_NUM-1:0] led,
    output logic [CH_NUM-1:0] pulse_done
);
    localparam logic [1:0] M_OFF   = 2'b00;
    localparam logic [1:0] M_BLINK = 2'b10;
    localparam logic [1:0] M_PULSE = 2'b11;
    localparam int PW = $clog2(PRESCALE);

    logic [PW-1:0] pre_cnt;
    logic          accept;

    assign accept = cfg_we && (int'(cfg_ch) < CH_NUM);

    // tick_o rises on the PRESCALE-th edge after reset release
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
            tick_o  <= 1'b0;
        end else begin
            pre_cnt <= (pre_cnt == PW'(PRESCALE - 1)) ? '0 : pre_cnt + 1'b1;
            tick_o  <= pre_cnt == PW'(PRESCALE - 1);
        end
    end

`ifdef LED_DIM_EN
    logic [DIM_W-1:0] pwm_cnt;
    always_ff @(posedge sclk or negedge rst_n) begin
        if (!rst_n) pwm_cnt <= '0;
        else        pwm_cnt <= pwm_cnt + 1'b1;
    end
`endif

    for (genvar i = 0; i < CH_NUM; i++) begin : g_ch
        logic [1:0]        mode, mode_nxt;
        logic [HALF_W-1:0] half, half_nxt, ph, ph_nxt, h_eff;
        logic [DIM_W-1:0]  duty, duty_nxt;
        logic              raw, raw_nxt, done, done_nxt, wr, phase_end;

        assign wr        = accept && (cfg_ch == CW'(i));
        assign h_eff     = (half == '0) ? HALF_W'(1) : half;
        // mode[1] set means BLINK or PULSE, the only modes that consume ticks
        assign phase_end = tick_o && mode[1] && (ph == h_eff - 1'b1);

        // a write overrides any tick arriving in the same cycle
        always_comb begin
            mode_nxt = wr ? cfg_mode : (phase_end && mode == M_PULSE) ? M_OFF : mode;
            half_nxt = wr ? cfg_half : half;
            duty_nxt = wr ? cfg_duty : duty;
            ph_nxt   = wr ? '0 : (tick_o && mode[1]) ? (phase_end ? '0 : ph + 1'b1) : ph;
            raw_nxt  = wr ? (cfg_mode != M_OFF) : phase_end ? (mode == M_BLINK && !raw) : raw;
            done_nxt = !wr && phase_end && mode == M_PULSE;
        end

        always_ff @(posedge sclk or negedge rst_n) begin
            if (!rst_n) begin
                mode <= M_OFF;
                half <= HALF_W'(1);
                duty <= '1;
                ph   <= '0;
                raw  <= 1'b0;
                done <= 1'b0;
            end else begin
                mode <= mode_nxt;
                half <= half_nxt;
                duty <= duty_nxt;
                ph   <= ph_nxt;
                raw  <= raw_nxt;
                done <= done_nxt;
            end
        end

        assign pulse_done[i] = done;

`ifdef LED_DIM_EN
        // gate the next raw state so dimming adds no delay to raw timing
        logic led_q;
        always_ff @(posedge sclk or negedge rst_n) begin
            if (!rst_n) led_q <= 1'b0;
            else        led_q <= raw_nxt && (duty_nxt == '1 || pwm_cnt < duty_nxt);
        end
        assign led[i] = led_q;
`else
        assign led[i] = raw;
`endif
    end
endmodule

// File: tb/tb_led_blink_ctrl.sv
// tb_led_blink_ctrl: directed self-checking bench for led_blink_ctrl
module tb_led_blink_ctrl;
    logic       sclk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_ch;
    logic [1:0] cfg_mode;
    logic [7:0] cfg_half;
    logic [3:0] cfg_duty;
    logic       tick_o;
    logic [3:0] led;
    logic [3:0] pulse_done;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int cnt;

    localparam logic [1:0] OFF = 2'b00, ON = 2'b01, BLINK = 2'b10, PULSE = 2'b11;

    led_blink_ctrl #(.CH_NUM(4), .PRESCALE(4), .HALF_W(8), .DIM_W(4)) dut (
        .sclk(sclk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_half(cfg_half), .cfg_duty(cfg_duty),
        .tick_o(tick_o), .led(led), .pulse_done(pulse_done)
    );

    always #5 sclk = ~sclk;

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int k);
        repeat (k) @(posedge sclk);
        #1;
        cyc += k;
    endtask

    task automatic go(input int c);
        clk_n(c - cyc);
    endtask

    task automatic wr(input logic [1:0] ch, input logic [1:0] m, input logic [7:0] h, input logic [3:0] d);
        cfg_we = 1'b1; cfg_ch = ch; cfg_mode = m; cfg_half = h; cfg_duty = d;
        clk_n(1);
        cfg_we = 1'b0;
    endtask

    task automatic count16;
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            clk_n(1);
            cnt += int'(led[0]);
        end
    endtask

    initial begin
        rst_n = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_mode = OFF; cfg_half = '0; cfg_duty = '0;
        repeat (2) @(posedge sclk);
        #1 rst_n = 1'b1;
        cyc = 0;
        wr(2'd1, BLINK, 8'd1, 4'hF);
        wr(2'd0, ON, 8'd1, 4'hF);
        chk("pre_reset_led", led, 4'b0011);
        go(4);
        chk("pre_reset_tick", tick_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("reset_led", led, 4'b0000);
        chk("reset_tick", tick_o, 1'b0);
        chk("reset_done", pulse_done, 4'b0000);
        @(posedge sclk);
        #1 rst_n = 1'b1;
        cyc = 0;
        go(3);  chk("tick_before_first", tick_o, 1'b0);
        go(4);  chk("tick_first", tick_o, 1'b1);
        wr(2'd3, BLINK, 8'd3, 4'hF);
        chk("wr_on_tick_led", led, 4'b1000);
        chk("tick_after_first", tick_o, 1'b0);
        go(6);  wr(2'd2, PULSE, 8'd2, 4'hF);
        chk("pulse_start", led, 4'b1100);
        go(9);  wr(2'd1, BLINK, 8'd3, 4'hF);
        chk("blink1_start", led, 4'b1110);
        go(12); chk("c12_led", led, 4'b1110);
        chk("c12_done", pulse_done, 4'b0000);
        go(13); chk("pulse_end_led", led, 4'b1010);
        chk("pulse_end_done", pulse_done, 4'b0100);
        go(14); chk("pulse_done_one_cycle", pulse_done, 4'b0000);
        go(16); chk("c16_led", led, 4'b1010);
        go(17); chk("ch3_full_3_ticks", led, 4'b0010);
        go(20); chk("c20_led", led, 4'b0010);
        go(21); chk("ch1_first_toggle", led, 4'b0000);
        go(28); chk("c28_led", led, 4'b0000);
        go(29); chk("ch3_period_12", led, 4'b1000);
        go(33); chk("ch1_period_12", led, 4'b1010);
        wr(2'd0, PULSE, 8'd2, 4'hF);
        go(37); wr(2'd0, ON, 8'd2, 4'hF);
        chk("pulse_to_on", led, 4'b1011);
        go(41); chk("aborted_pulse_led", led, 4'b0011);
        chk("aborted_pulse_done", pulse_done, 4'b0000);
        go(42); chk("aborted_pulse_done2", pulse_done, 4'b0000);
        go(45); chk("c45_led", led, 4'b0001);
        wr(2'd2, BLINK, 8'd0, 4'hF);
        chk("half0_start", led, 4'b0101);
        go(48); chk("half0_c48", led, 4'b0101);
        go(49); chk("half0_toggle1", led, 4'b0001);
        go(52); chk("half0_c52", led, 4'b0001);
        go(53); chk("half0_toggle2", led, 4'b1101);
        wr(2'd0, ON, 8'd1, 4'd8);
        count16;
`ifdef LED_DIM_EN
        chk("duty8_high_count", cnt, 8);
`else
        chk("duty8_high_count", cnt, 16);
`endif
        wr(2'd0, ON, 8'd1, 4'd15);
        count16;
        chk("duty15_high_count", cnt, 16);
        wr(2'd0, ON, 8'd1, 4'd0);
        count16;
`ifdef LED_DIM_EN
        chk("duty0_high_count", cnt, 0);
`else
        chk("duty0_high_count", cnt, 16);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
